// File: rtl/output_channel_issue_scheduler_pkg.sv
// Shared channel-buffer constants and types for the output channel issue scheduler.
// Round-robin arbitration is selected by defining OUTPUT_CHANNEL_SCHEDULER_ROUND_ROBIN_EN.
package output_channel_issue_scheduler_pkg;

  localparam int TIA_NUM_OUTPUT_CHANNELS        = 4;
  localparam int TIA_CHANNEL_BUFFER_FIFO_DEPTH  = 4;
  localparam int TIA_CHANNEL_BUFFER_COUNT_WIDTH = $clog2(TIA_CHANNEL_BUFFER_FIFO_DEPTH + 1);
  localparam int TIA_OCI_WIDTH                  = TIA_NUM_OUTPUT_CHANNELS;

  typedef logic [TIA_OCI_WIDTH-1:0] oci_t;

  // A one-requester arbiter still needs a legal, non-zero pointer width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_channel_request_arbiter.sv
// Picks one eligible requester per cycle: round-robin when
// OUTPUT_CHANNEL_SCHEDULER_ROUND_ROBIN_EN is defined, lowest index first otherwise.
module output_channel_request_arbiter
  import output_channel_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] eligible,
  output logic [NUM_REQUESTERS-1:0] grant
);

`ifdef OUTPUT_CHANNEL_SCHEDULER_ROUND_ROBIN_EN

  localparam int PW = ptr_width(NUM_REQUESTERS);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    ptr_d = ptr_q;
    idx   = 0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQUESTERS;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        ptr_d      = PW'((idx + 1) % NUM_REQUESTERS);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

`else

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!found && eligible[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Fixed priority keeps no state; clock and reset are kept only for a uniform port list.
  logic unused_ok;
  assign unused_ok = clock ^ reset_n;

`endif

endmodule

// File: rtl/output_channel_issue_scheduler.sv
// Output channel issue scheduler: grants requests only when every target channel has room
// counting in-flight writes. Arbitration mode set by OUTPUT_CHANNEL_SCHEDULER_ROUND_ROBIN_EN.
module output_channel_issue_scheduler
  import output_channel_issue_scheduler_pkg::*;
#(
  parameter  int NUM_OUTPUT_CHANNELS = TIA_NUM_OUTPUT_CHANNELS,
  parameter  int FIFO_DEPTH          = TIA_CHANNEL_BUFFER_FIFO_DEPTH,
  parameter  int NUM_REQUESTERS      = 4,
  parameter  int PIPELINE_DEPTH      = 2,
  localparam int CW                  = $clog2(FIFO_DEPTH + 1),
  localparam int RW                  = CW + 1
) (
  input  logic                                                clock,
  input  logic                                                reset_n,
  input  logic                                                halt,
  input  logic [NUM_REQUESTERS-1:0]                           request_valid,
  input  logic [NUM_REQUESTERS-1:0][NUM_OUTPUT_CHANNELS-1:0]  request_oci,
  input  logic [NUM_OUTPUT_CHANNELS-1:0]                      dequeue,
  output logic [NUM_REQUESTERS-1:0]                           grant,
  output logic                                                issue_valid,
  output logic [NUM_OUTPUT_CHANNELS-1:0]                      issue_oci,
  output logic [NUM_OUTPUT_CHANNELS-1:0][CW-1:0]              output_channel_counts,
  output logic [NUM_OUTPUT_CHANNELS-1:0]                      output_channel_full_status,
  output logic                                                underflow_error
);

  logic [NUM_OUTPUT_CHANNELS-1:0][CW-1:0]            count_q;
  logic [NUM_OUTPUT_CHANNELS-1:0][CW-1:0]            count_d;
  logic [PIPELINE_DEPTH-1:0][NUM_OUTPUT_CHANNELS-1:0] inflight_q;
  logic [PIPELINE_DEPTH-1:0][NUM_OUTPUT_CHANNELS-1:0] inflight_d;
  logic                                              underflow_q;
  logic                                              underflow_d;

  logic [NUM_OUTPUT_CHANNELS-1:0][RW-1:0] reserved;
  logic [NUM_OUTPUT_CHANNELS-1:0]         room;
  logic [NUM_OUTPUT_CHANNELS-1:0]         retire;
  logic [NUM_REQUESTERS-1:0]              eligible;
  logic                                   issue_enable;

  assign issue_enable = reset_n & ~halt;

  // Reservation counts buffered entries plus every write still travelling down the pipe.
  always_comb begin
    reserved = '0;
    room     = '0;
    for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
      reserved[c] = RW'(count_q[c]);
      for (int s = 0; s < PIPELINE_DEPTH; s++) begin
        reserved[c] = reserved[c] + RW'(inflight_q[s][c]);
      end
      room[c] = (reserved[c] < RW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      eligible[i] = request_valid[i] & issue_enable;
      for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
        if (request_oci[i][c] && !room[c]) eligible[i] = 1'b0;
      end
    end
  end

  output_channel_request_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_arbiter (
    .clock   (clock),
    .reset_n (reset_n),
    .eligible(eligible),
    .grant   (grant)
  );

  always_comb begin
    issue_oci = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant[i]) issue_oci = issue_oci | request_oci[i];
    end
  end

  assign issue_valid = |grant;

  // A stalled pipe neither shifts nor retires; dequeues from downstream still land.
  always_comb begin
    inflight_d  = inflight_q;
    retire      = '0;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (!halt) begin
      retire        = inflight_q[PIPELINE_DEPTH-1];
      inflight_d[0] = issue_oci;
      for (int s = 1; s < PIPELINE_DEPTH; s++) begin
        inflight_d[s] = inflight_q[s-1];
      end
    end
    for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
      if (retire[c] && !dequeue[c]) begin
        count_d[c] = count_q[c] + CW'(1);
      end else if (dequeue[c] && !retire[c]) begin
        if (count_q[c] == '0) underflow_d = 1'b1;
        else                  count_d[c]  = count_q[c] - CW'(1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q     <= '0;
      // NOTE: the in-flight register is reset too; stale OCI bits would otherwise retire into empty channels.
      inflight_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
    end
  end

  assign output_channel_counts      = count_q;
  assign output_channel_full_status = ~room;
  assign underflow_error            = underflow_q;

endmodule

// File: tb/tb_output_channel_issue_scheduler.sv
// Scoreboard bench for output_channel_issue_scheduler: directed test-plan scenarios
// followed by randomized traffic, checked against a queue-based reference model.
module tb_output_channel_issue_scheduler;
  import output_channel_issue_scheduler_pkg::*;

  localparam int NC    = TIA_NUM_OUTPUT_CHANNELS;
  localparam int DEPTH = TIA_CHANNEL_BUFFER_FIFO_DEPTH;
  localparam int NR    = 4;
  localparam int PD    = 2;
  localparam int CW    = TIA_CHANNEL_BUFFER_COUNT_WIDTH;

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic                     halt;
  logic [NR-1:0]            request_valid;
  logic [NR-1:0][NC-1:0]    request_oci;
  logic [NC-1:0]            dequeue;
  logic [NR-1:0]            grant;
  logic                     issue_valid;
  logic [NC-1:0]            issue_oci;
  logic [NC-1:0][CW-1:0]    output_channel_counts;
  logic [NC-1:0]            output_channel_full_status;
  logic                     underflow_error;

  output_channel_issue_scheduler #(
    .NUM_OUTPUT_CHANNELS(NC),
    .FIFO_DEPTH         (DEPTH),
    .NUM_REQUESTERS     (NR),
    .PIPELINE_DEPTH     (PD)
  ) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .halt                      (halt),
    .request_valid             (request_valid),
    .request_oci               (request_oci),
    .dequeue                   (dequeue),
    .grant                     (grant),
    .issue_valid               (issue_valid),
    .issue_oci                 (issue_oci),
    .output_channel_counts     (output_channel_counts),
    .output_channel_full_status(output_channel_full_status),
    .underflow_error           (underflow_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NR-1:0]    grant;
    logic             issue_valid;
    logic [NC-1:0]    issue_oci;
    logic [NC*CW-1:0] counts;
    logic [NC-1:0]    full;
    logic             uf;
  } exp_t;

  typedef struct {
    oci_t oci;
    int   rem;
  } pend_t;

  exp_t  sb_q[$];
  pend_t pend_q[$];
  int    m_count[NC];
  int    m_ptr;
  bit    m_uf;
  int    n_cmp;
  int    n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_reserved(input int c);
    int r;
    r = m_count[c];
    foreach (pend_q[p]) if (pend_q[p].oci[c]) r++;
    return r;
  endfunction

  function automatic int model_pick();
    int idx;
    bit ok;
    if (!reset_n || halt) return -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (request_valid[idx]) begin
        ok = 1'b1;
        for (int c = 0; c < NC; c++)
          if (request_oci[idx][c] && model_reserved(c) >= DEPTH) ok = 1'b0;
        if (ok) return idx;
      end
    end
    return -1;
  endfunction

  function automatic exp_t model_expect(input int g);
    exp_t e;
    e.grant       = '0;
    e.issue_valid = (g >= 0);
    e.issue_oci   = '0;
    if (g >= 0) begin
      e.grant[g]  = 1'b1;
      e.issue_oci = request_oci[g];
    end
    for (int c = 0; c < NC; c++) begin
      e.counts[c*CW +: CW] = CW'(m_count[c]);
      e.full[c]            = (model_reserved(c) >= DEPTH);
    end
    e.uf = m_uf;
    return e;
  endfunction

  task automatic model_edge(input int g);
    pend_t keep[$];
    oci_t  r;
    int    nc;
    if (!reset_n) begin
      foreach (m_count[c]) m_count[c] = 0;
      pend_q.delete();
      m_ptr = 0;
      m_uf  = 1'b0;
      return;
    end
    r = '0;
    if (!halt) begin
      foreach (pend_q[p]) begin
        pend_t e;
        e = pend_q[p];
        e.rem--;
        if (e.rem == 0) r = r | e.oci;
        else            keep.push_back(e);
      end
      pend_q = keep;
    end
    if (g >= 0) begin
      pend_t n;
      n.oci = request_oci[g];
      n.rem = PD;
      pend_q.push_back(n);
`ifdef OUTPUT_CHANNEL_SCHEDULER_ROUND_ROBIN_EN
      m_ptr = (g + 1) % NR;
`endif
    end
    for (int c = 0; c < NC; c++) begin
      nc = m_count[c] + int'(r[c]);
      assert (nc <= DEPTH) else $error("retire into a full channel %0d", c);
      if (dequeue[c]) begin
        if (nc > 0) nc--;
        else        m_uf = 1'b1;
      end
      m_count[c] = nc;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rn, input logic h, input logic [NR-1:0] v,
                       input logic [NR-1:0][NC-1:0] oci, input logic [NC-1:0] dq);
    int g;
    reset_n       = rn;
    halt          = h;
    request_valid = v;
    request_oci   = oci;
    dequeue       = dq;
    g = model_pick();
    sb_q.push_back(model_expect(g));
    @(posedge clock);
    model_edge(g);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, '0);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("grant",       32'(grant),                      32'(mon_e.grant));
      check("issue_valid", 32'(issue_valid),                32'(mon_e.issue_valid));
      check("issue_oci",   32'(issue_oci),                  32'(mon_e.issue_oci));
      check("counts",      32'(output_channel_counts),      32'(mon_e.counts));
      check("full_status", 32'(output_channel_full_status), 32'(mon_e.full));
      check("underflow",   32'(underflow_error),            32'(mon_e.uf));
    end
  end

  // ---------------- stimulus ----------------
  logic [NR-1:0][NC-1:0] oci_v;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_ptr = 0;
    m_uf  = 1'b0;
    foreach (m_count[c]) m_count[c] = 0;

    // First edge initialises the DUT; checking starts afterwards.
    reset_n = 1'b0; halt = 1'b0; request_valid = '1; request_oci = '0; dequeue = '0;
    @(posedge clock);
    model_edge(-1);
    #1;

    // Reset held with requests active.
    oci_v = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    repeat (2) cycle(1'b0, 1'b0, 4'b1111, oci_v, '0);

    // Requester 0 fills channel 0.
    oci_v = '0; oci_v[0] = 4'b0001;
    repeat (8) cycle(1'b1, 1'b0, 4'b0001, oci_v, '0);

    // Retire coinciding with dequeue on channel 1 at count 2.
    cycle(1'b0, 1'b0, '0, '0, '0);
    oci_v = '0; oci_v[0] = 4'b0010;
    repeat (2) cycle(1'b1, 1'b0, 4'b0001, oci_v, '0);
    idle(3);
    cycle(1'b1, 1'b0, 4'b0001, oci_v, '0);
    idle(1);
    cycle(1'b1, 1'b0, '0, '0, 4'b0010);
    idle(2);

    // Three always-valid requesters on disjoint channels.
    cycle(1'b0, 1'b0, '0, '0, '0);
    oci_v = {4'b0000, 4'b0100, 4'b0010, 4'b0001};
    repeat (8) cycle(1'b1, 1'b0, 4'b0111, oci_v, '0);

    // Halt holds an in-flight entry.
    cycle(1'b0, 1'b0, '0, '0, '0);
    oci_v = '0; oci_v[0] = 4'b1000;
    cycle(1'b1, 1'b0, 4'b0001, oci_v, '0);
    repeat (3) cycle(1'b1, 1'b1, 4'b0001, oci_v, '0);
    idle(3);

    // Underflow on an empty channel is sticky until reset.
    cycle(1'b1, 1'b0, '0, '0, 4'b0100);
    idle(3);
    cycle(1'b0, 1'b0, '0, '0, '0);
    idle(1);

    // Randomized traffic, including zero-OCI requests and mid-flight resets.
    for (int n = 0; n < 800; n++) begin
      logic rn, h;
      logic [NR-1:0] v;
      logic [NC-1:0] dq;
      for (int i = 0; i < NR; i++) begin
        oci_v[i] = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom_range(1, (1 << NC) - 1));
      end
      v  = NR'($urandom_range(0, (1 << NR) - 1));
      dq = '0;
      for (int c = 0; c < NC; c++) dq[c] = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 5) == 0);
      rn = ($urandom_range(0, 99) != 0);
      cycle(rn, h, v, oci_v, dq);
    end
    idle(2);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(negedge clock);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
